// File: rtl/glb_pkg.sv
// Shared FSM/readout-source encodings and saturating arithmetic for the psum accumulator.
package glb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  typedef enum logic [1:0] {
    RSRC_ZERO = 2'd0,
    RSRC_BANK = 2'd1,
    RSRC_FWD  = 2'd2
  } rd_src_e;

  localparam int SAT_W = 32;

  // Operands arrive sign-extended to SAT_W; result is clamped to a signed 'width'-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             width
  );
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    one   = {{SAT_W{1'b0}}, 1'b1};
    sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    max_v = (one <<< (width - 1)) - one;
    min_v = -(one <<< (width - 1));
    if (sum > max_v) begin
      return max_v[SAT_W-1:0];
    end else if (sum < min_v) begin
      return min_v[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/glb_psum_accum_if.sv
// Psum router write port, clear control and readout port of the global-buffer psum accumulator.
interface glb_psum_accum_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10
);
  logic                         write_en_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum;
  logic                         accum_en;
  logic                         clear_req;
  logic                         clear_busy;
  logic                         read_req_out;
  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_out;
  logic [DATA_BITWIDTH-1:0]     r_data_out;
  logic                         r_valid_out;
  logic                         err_flag;

  modport master (
    output write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, accum_en,
    output clear_req, read_req_out, r_addr_out,
    input  clear_busy, r_data_out, r_valid_out, err_flag
  );

  modport slave (
    input  write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, accum_en,
    input  clear_req, read_req_out, r_addr_out,
    output clear_busy, r_data_out, r_valid_out, err_flag
  );
endinterface

// File: rtl/psum_bank.sv
// Psum storage: one write port, one combinational read (accumulate operand), one registered read (readout).
// Latency: write lands at the clock edge; accumulate read is same-cycle; readout read is one cycle.
// Backpressure: none, every port is usable every cycle.
module psum_bank #(
  parameter int DATA_BITWIDTH = 16,
  parameter int PSUM_DEPTH    = 64,
  parameter int IDX_W         = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DATA_BITWIDTH-1:0] wr_dat,
  input  logic [IDX_W-1:0]         acc_idx,
  output logic [DATA_BITWIDTH-1:0] acc_dat,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_BITWIDTH-1:0] rd_dat
);

  logic [DATA_BITWIDTH-1:0] mem [PSUM_DEPTH];

  assign acc_dat = mem[acc_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PSUM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_dat <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_dat;
      end
      if (rd_en) begin
        rd_dat <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/glb_psum_accum.sv
// Global-buffer psum accumulator: overwrite or saturating-accumulate writes, readout port, sequential clear.
// Latency: write commits one cycle after capture; readout data one cycle after request; clear takes PSUM_DEPTH cycles.
// Backpressure: none; writes during clear or out of range are dropped and flagged in err_flag.
module glb_psum_accum
  import glb_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int PSUM_DEPTH        = 64,
  parameter int PSUM_LOAD_ADDR    = 0
) (
  input  logic             clk,
  input  logic             reset,
  glb_psum_accum_if.slave  bus
);

  localparam int          IDX_W   = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
  localparam int unsigned HI_EXCL = PSUM_LOAD_ADDR + PSUM_DEPTH;

  function automatic logic addr_in_rng(input logic [ADDR_BITWIDTH_GLB-1:0] a);
    return (32'(a) >= 32'(PSUM_LOAD_ADDR)) && (32'(a) < HI_EXCL);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_BITWIDTH_GLB-1:0] a);
    return IDX_W'(32'(a) - 32'(PSUM_LOAD_ADDR));
  endfunction

  clr_state_e               state_q;
  logic [IDX_W-1:0]         cnt_q;
  logic                     busy_q;
  logic                     stg_vld_q;
  logic [IDX_W-1:0]         stg_idx_q;
  logic [DATA_BITWIDTH-1:0] stg_dat_q;
  logic                     stg_acc_q;
  logic                     err_q;
  logic                     r_vld_q;
  rd_src_e                  r_src_q;
  logic [DATA_BITWIDTH-1:0] r_fwd_q;

  logic                     w_in;
  logic [IDX_W-1:0]         w_idx;
  logic                     r_in;
  logic [IDX_W-1:0]         r_idx;
  logic                     clearing;
  logic                     wr_ok;
  logic                     err_set;
  logic [DATA_BITWIDTH-1:0] commit_dat;
  logic                     bank_wr_en;
  logic [IDX_W-1:0]         bank_wr_idx;
  logic [DATA_BITWIDTH-1:0] bank_wr_dat;
  logic [DATA_BITWIDTH-1:0] bank_acc_dat;
  logic [DATA_BITWIDTH-1:0] bank_rd_dat;
  logic                     hit_wr;
  logic                     hit_stg;
  logic [DATA_BITWIDTH-1:0] fwd_dat;

  assign w_in     = addr_in_rng(bus.w_addr_glb_psum);
  assign w_idx    = addr_idx(bus.w_addr_glb_psum);
  assign r_in     = addr_in_rng(bus.r_addr_out);
  assign r_idx    = addr_idx(bus.r_addr_out);
  assign clearing = (state_q == CLEAR);
  assign wr_ok    = bus.write_en_glb_psum && w_in && !clearing;
  assign err_set  = (bus.write_en_glb_psum && !wr_ok) || (bus.read_req_out && !r_in);

  // The stored operand is read in the commit cycle, so the previous write to the same
  // index has already landed in the bank and back-to-back accumulates chain correctly.
  assign commit_dat = stg_acc_q
    ? DATA_BITWIDTH'(sat_add(SAT_W'($signed(bank_acc_dat)), SAT_W'($signed(stg_dat_q)), DATA_BITWIDTH))
    : stg_dat_q;

  // While clearing, the write port belongs to the clear sweep; a write staged just
  // before the clear is held and forwarded to reads until the sweep reaches its index.
  assign bank_wr_en  = clearing || stg_vld_q;
  assign bank_wr_idx = clearing ? cnt_q : stg_idx_q;
  assign bank_wr_dat = clearing ? '0 : commit_dat;

  assign hit_wr  = bank_wr_en && (bank_wr_idx == r_idx);
  assign hit_stg = stg_vld_q && (stg_idx_q == r_idx);
  assign fwd_dat = hit_wr ? bank_wr_dat : commit_dat;

  psum_bank #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .PSUM_DEPTH    (PSUM_DEPTH),
    .IDX_W         (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_wr_en),
    .wr_idx  (bank_wr_idx),
    .wr_dat  (bank_wr_dat),
    .acc_idx (stg_idx_q),
    .acc_dat (bank_acc_dat),
    .rd_en   (bus.read_req_out && r_in),
    .rd_idx  (r_idx),
    .rd_dat  (bank_rd_dat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_idx_q <= '0;
      stg_dat_q <= '0;
      stg_acc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stg_vld_q <= wr_ok;
          if (wr_ok) begin
            stg_idx_q <= w_idx;
            stg_dat_q <= bus.w_data_glb_psum;
            stg_acc_q <= bus.accum_en;
          end
          if (bus.clear_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          stg_vld_q <= stg_vld_q && (stg_idx_q != cnt_q);
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(PSUM_DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      r_vld_q <= 1'b0;
      r_src_q <= RSRC_ZERO;
      r_fwd_q <= '0;
    end else begin
      err_q   <= err_q || err_set;
      r_vld_q <= bus.read_req_out;
      if (bus.read_req_out) begin
        if (!r_in) begin
          r_src_q <= RSRC_ZERO;
        end else if (hit_wr || hit_stg) begin
          r_src_q <= RSRC_FWD;
        end else begin
          r_src_q <= RSRC_BANK;
        end
        r_fwd_q <= fwd_dat;
      end
    end
  end

  always_comb begin
    bus.r_data_out = '0;
    case (r_src_q)
      RSRC_BANK: bus.r_data_out = bank_rd_dat;
      RSRC_FWD:  bus.r_data_out = r_fwd_q;
      default:   bus.r_data_out = '0;
    endcase
  end

  assign bus.clear_busy  = busy_q;
  assign bus.r_valid_out = r_vld_q;
  assign bus.err_flag    = err_q;

endmodule

// File: tb/tb_glb_psum_accum.sv
// Scoreboard bench: a cycle-level array model predicts every read and the per-cycle control outputs.
module tb_glb_psum_accum;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 64;
  localparam int BASE  = 0;

  typedef struct packed {
    bit busy;
    bit err;
    bit rvld;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  glb_psum_accum_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) bus ();

  glb_psum_accum #(
    .DATA_BITWIDTH     (DW),
    .ADDR_BITWIDTH_GLB (AW),
    .PSUM_DEPTH        (DEPTH),
    .PSUM_LOAD_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   mem [DEPTH];
  int   clr_idx  = -1;
  bit   m_err    = 1'b0;
  bit   mon_en   = 1'b0;
  int   rd_q [$];
  ctl_t ctl_q [$];
  ctl_t mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input int a);
    return (a >= BASE) && (a < BASE + DEPTH);
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One clock cycle of stimulus; the model sees reads before this cycle's write.
  task automatic step(input bit we, input int waddr, input int wdata, input bit acc,
                      input bit clr, input bit rd, input int raddr);
    ctl_t e;
    bit   busy;
    @(posedge clk);
    #1;
    bus.write_en_glb_psum = we;
    bus.w_addr_glb_psum   = AW'(waddr);
    bus.w_data_glb_psum   = DW'(wdata);
    bus.accum_en          = acc;
    bus.clear_req         = clr;
    bus.read_req_out      = rd;
    bus.r_addr_out        = AW'(raddr);
    busy = (clr_idx >= 0);
    if (busy) mem[clr_idx] = 0;
    if (rd) begin
      if (in_rng(raddr)) begin
        rd_q.push_back(mem[raddr - BASE]);
      end else begin
        rd_q.push_back(0);
        m_err = 1'b1;
      end
    end
    if (we) begin
      if (busy || !in_rng(waddr)) m_err = 1'b1;
      else mem[waddr - BASE] = acc ? sat(mem[waddr - BASE] + wdata) : wdata;
    end
    if (busy) begin
      clr_idx++;
      if (clr_idx == DEPTH) clr_idx = -1;
    end else if (clr) begin
      clr_idx = 0;
    end
    e.busy = (clr_idx >= 0);
    e.err  = m_err;
    e.rvld = rd;
    ctl_q.push_back(e);
  endtask

  task automatic wr(input int addr, input int data, input bit acc);
    step(1'b1, addr, data, acc, 1'b0, 1'b0, 0);
  endtask

  task automatic rd(input int addr);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) rd(BASE + a);
  endtask

  task automatic reset_seq();
    ctl_t z;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.write_en_glb_psum = 1'b0;
    bus.accum_en          = 1'b0;
    bus.clear_req         = 1'b0;
    bus.read_req_out      = 1'b0;
    bus.w_addr_glb_psum   = '0;
    bus.w_data_glb_psum   = '0;
    bus.r_addr_out        = '0;
    rd_q.delete();
    ctl_q.delete();
    for (int i = 0; i < DEPTH; i++) mem[i] = 0;
    clr_idx = -1;
    m_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clear_busy", int'(bus.clear_busy), 0);
    chk("rst_r_valid_out", int'(bus.r_valid_out), 0);
    chk("rst_r_data_out", int'(bus.r_data_out), 0);
    chk("rst_err_flag", int'(bus.err_flag), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    z = '0;
    ctl_q.push_back(z);
    ctl_q.push_back(z);
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (ctl_q.size() == 0) begin
        chk("ctl_queue_underflow", 1, 0);
      end else begin
        mon_e = ctl_q.pop_front();
        chk("clear_busy", int'(bus.clear_busy), int'(mon_e.busy));
        chk("err_flag", int'(bus.err_flag), int'(mon_e.err));
        chk("r_valid_out", int'(bus.r_valid_out), int'(mon_e.rvld));
      end
      if (bus.r_valid_out) begin
        if (rd_q.size() == 0) chk("rd_queue_underflow", 1, 0);
        else chk("r_data_out", int'($signed(bus.r_data_out)), rd_q.pop_front());
      end
    end
  end

  initial begin
    int wa;
    int wd;
    int ra;
    bus.write_en_glb_psum = 1'b0;
    bus.w_addr_glb_psum   = '0;
    bus.w_data_glb_psum   = '0;
    bus.accum_en          = 1'b0;
    bus.clear_req         = 1'b0;
    bus.read_req_out      = 1'b0;
    bus.r_addr_out        = '0;
    reset_seq();

    // overwrite, then read two cycles later
    wr(BASE + 3, 5, 1'b0);
    idle(1);
    rd(BASE + 3);
    // back-to-back accumulate hazard, read immediately after
    wr(BASE + 7, 10, 1'b1);
    wr(BASE + 7, 20, 1'b1);
    wr(BASE + 7, 30, 1'b1);
    rd(BASE + 7);
    // saturation both directions
    wr(BASE + 9, 32000, 1'b0);
    wr(BASE + 9, 1000, 1'b1);
    rd(BASE + 9);
    wr(BASE + 10, -32000, 1'b0);
    wr(BASE + 10, -1000, 1'b1);
    rd(BASE + 10);
    idle(2);

    // fill with 1, clear with a write staged at the clear pulse, reads sweep during clear
    for (int a = 0; a < DEPTH; a++) wr(BASE + a, 1, 1'b0);
    step(1'b1, BASE + 40, 7, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, BASE + 40);
      else if (i == 10) step(1'b1, BASE + 5, 3, 1'b0, 1'b1, 1'b1, BASE + DEPTH - 1 - i);
      else step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, BASE + DEPTH - 1 - i);
    end
    idle(1);
    read_all();
    idle(2);

    // out-of-range write and read leave contents untouched
    reset_seq();
    for (int a = 0; a < DEPTH; a += 5) wr(BASE + a, a * 3 - 50, 1'b0);
    wr(BASE + DEPTH, 999, 1'b0);
    wr(1023, 777, 1'b1);
    rd(BASE + DEPTH);
    read_all();
    idle(2);

    // reset while the clear sweep is at index 20
    reset_seq();
    for (int a = 0; a < DEPTH; a++) wr(BASE + a, a + 100, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    idle(20);
    reset_seq();
    read_all();
    wr(BASE + 2, 11, 1'b1);
    rd(BASE + 2);
    idle(2);

    // randomized traffic
    reset_seq();
    for (int i = 0; i < 1500; i++) begin
      wa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wa = int'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) begin
        wd = 30000 + int'($urandom_range(0, 2767));
        if ($urandom_range(0, 1) == 1) wd = -wd;
      end else begin
        wd = int'($urandom_range(0, 65535)) - 32768;
      end
      step(($urandom_range(0, 3) != 0), wa, wd, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 249) == 0), ($urandom_range(0, 1) == 1), ra);
    end
    idle(DEPTH + 2);
    read_all();
    idle(3);
    chk("rd_queue_drain", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
